// File: rtl/usb_crc_engine_if.sv
// Bus between the USB packet FSMs and the serial CRC engine.
// Both streams transfer a bit on a clock edge where valid && ready; valid never waits on ready.
interface usb_crc_engine_if #(
    parameter int CRC_W = 16,
    parameter int LEN_W = 11
);
    logic             start;
    logic             mode;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             din_valid;
    logic             din;
    logic             din_ready;
    logic             crc_out_valid;
    logic             crc_out;
    logic             out_ready;
    logic [CRC_W-1:0] crc_value;
    logic             done;
    logic             crc_ok;
    logic             ack;
    logic             busy;
    logic [1:0]       state_dbg;

    modport master (
        output start, mode, len, abort, din_valid, din, out_ready, ack,
        input  din_ready, crc_out_valid, crc_out, crc_value, done, crc_ok, busy, state_dbg
    );

    modport slave (
        input  start, mode, len, abort, din_valid, din, out_ready, ack,
        output din_ready, crc_out_valid, crc_out, crc_value, done, crc_ok, busy, state_dbg
    );
endinterface

// File: rtl/usb_crc_engine.sv
// Serial LSB-first CRC engine: generate mode emits the complemented remainder MSB-first,
// check mode compares the final register against the polynomial residual.
module usb_crc_engine #(
    parameter int               CRC_W    = 16,
    parameter logic [CRC_W-1:0] POLY     = 16'h8005,
    parameter logic [CRC_W-1:0] RESIDUAL = 16'h800D,
    parameter int               LEN_W    = 11
) (
    input logic clk,
    input logic rst_n,
    usb_crc_engine_if.slave bus
);
    localparam int EW = (CRC_W > 1) ? $clog2(CRC_W) : 1;
    localparam logic [EW-1:0] EMIT_LAST = EW'(CRC_W - 1);
    localparam logic [CRC_W-1:0] ONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [CRC_W-1:0] crc, crc_next, shreg, crc_value_q;
    logic [LEN_W-1:0] count, len_q;
    logic [EW-1:0]    emit_cnt;
    logic             mode_q, crc_ok_q;
    logic             accept, last_bit, fb;

    logic din_ready_c, crc_out_valid_c, crc_out_c, done_c, busy_c;

    assign accept   = bus.din_valid && (state == DATA);
    assign last_bit = (count == len_q - LEN_W'(1));
    assign fb       = crc[CRC_W-1] ^ bus.din;
    assign crc_next = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    if (bus.len != '0) state_next = DATA;
                    else if (bus.mode) state_next = DONE;
                    else               state_next = EMIT;
                end
                DATA: if (accept && last_bit) state_next = mode_q ? DONE : EMIT;
                EMIT: if (bus.out_ready && emit_cnt == EMIT_LAST) state_next = DONE;
                DONE: if (bus.ack) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        din_ready_c     = 1'b0;
        crc_out_valid_c = 1'b0;
        crc_out_c       = 1'b0;
        done_c          = 1'b0;
        case (state)
            DATA: din_ready_c = 1'b1;
            EMIT: begin
                crc_out_valid_c = 1'b1;
                crc_out_c       = shreg[CRC_W-1];
            end
            DONE: done_c = 1'b1;
            default: ;
        endcase
        busy_c = (state != IDLE);
    end

    // Abort freezes the datapath; the CRC register is only reloaded by the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc         <= ONES;
            count       <= '0;
            len_q       <= '0;
            mode_q      <= 1'b0;
            shreg       <= '0;
            crc_value_q <= '0;
            emit_cnt    <= '0;
            crc_ok_q    <= 1'b0;
        end else if (bus.abort) begin
            crc_ok_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    crc      <= ONES;
                    count    <= '0;
                    len_q    <= bus.len;
                    mode_q   <= bus.mode;
                    emit_cnt <= '0;
                    if (bus.len == '0) begin
                        if (bus.mode) begin
                            crc_ok_q <= (ONES == RESIDUAL);
                        end else begin
                            shreg       <= ~ONES;
                            crc_value_q <= ~ONES;
                        end
                    end
                end
                DATA: if (accept) begin
                    crc   <= crc_next;
                    count <= count + LEN_W'(1);
                    if (last_bit) begin
                        if (mode_q) begin
                            crc_ok_q <= (crc_next == RESIDUAL);
                        end else begin
                            shreg       <= ~crc_next;
                            crc_value_q <= ~crc_next;
                        end
                    end
                end
                EMIT: if (bus.out_ready) begin
                    shreg    <= {shreg[CRC_W-2:0], 1'b0};
                    emit_cnt <= emit_cnt + EW'(1);
                end
                DONE: if (bus.ack) crc_ok_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.din_ready     = din_ready_c;
    assign bus.crc_out_valid = crc_out_valid_c;
    assign bus.crc_out       = crc_out_c;
    assign bus.done          = done_c;
    assign bus.busy          = busy_c;
    assign bus.crc_ok        = crc_ok_q;
    assign bus.crc_value     = crc_value_q;
    assign bus.state_dbg     = state;
endmodule

// File: tb/tb_usb_crc_engine.sv
// Self-checking bench for usb_crc_engine: a CRC16 and a CRC5 instance checked against a
// long-division reference model, plus directed stall, abort, start-ignore and reset cases.
module tb_usb_crc_engine;
  logic clk, rst_n;
  logic start, mode, abort, din_valid, din, out_ready, ack, sel5;
  logic [10:0] len;
  int n_tests = 0;
  int n_fail = 0;

  usb_crc_engine_if #(.CRC_W(16), .LEN_W(11)) if16 ();
  usb_crc_engine_if #(.CRC_W(5),  .LEN_W(11)) if5 ();

  usb_crc_engine #(.CRC_W(16), .POLY(16'h8005), .RESIDUAL(16'h800D), .LEN_W(11))
    dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  usb_crc_engine #(.CRC_W(5), .POLY(5'h05), .RESIDUAL(5'h0C), .LEN_W(11))
    dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));

  // Only the selected instance ever sees start; the other stays idle.
  assign if16.start = start & ~sel5;
  assign if5.start  = start & sel5;
  assign if16.mode = mode;           assign if5.mode = mode;
  assign if16.len = len;             assign if5.len = len;
  assign if16.abort = abort;         assign if5.abort = abort;
  assign if16.din_valid = din_valid; assign if5.din_valid = din_valid;
  assign if16.din = din;             assign if5.din = din;
  assign if16.out_ready = out_ready; assign if5.out_ready = out_ready;
  assign if16.ack = ack;             assign if5.ack = ack;

  logic o_din_ready, o_valid, o_bit, o_done, o_ok, o_busy;
  logic [15:0] o_value;
  logic [1:0] o_state;
  assign o_din_ready = sel5 ? if5.din_ready : if16.din_ready;
  assign o_valid     = sel5 ? if5.crc_out_valid : if16.crc_out_valid;
  assign o_bit       = sel5 ? if5.crc_out : if16.crc_out;
  assign o_done      = sel5 ? if5.done : if16.done;
  assign o_ok        = sel5 ? if5.crc_ok : if16.crc_ok;
  assign o_busy      = sel5 ? if5.busy : if16.busy;
  assign o_value     = sel5 ? {11'b0, if5.crc_value} : if16.crc_value;
  assign o_state     = sel5 ? if5.state_dbg : if16.state_dbg;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cur_w();
    return sel5 ? 5 : 16;
  endfunction

  function automatic logic [15:0] cur_poly();
    return sel5 ? 16'h0005 : 16'h8005;
  endfunction

  function automatic logic [15:0] cur_res();
    return sel5 ? 16'h000C : 16'h800D;
  endfunction

  // Register contents after n bits = (ones * x^n + D(x) * x^w) mod P, by textbook long division.
  function automatic logic [15:0] model_rem(input logic [127:0] msg, input int n,
                                            input int w, input logic [15:0] poly);
    bit a [0:159];
    bit pf [0:16];
    logic [15:0] r;
    pf[0] = 1'b1;
    for (int j = 1; j <= w; j++) pf[j] = poly[w-j];
    for (int i = 0; i < n + w; i++) a[i] = (i < w) ^ ((i < n) ? msg[i] : 1'b0);
    for (int i = 0; i < n; i++)
      if (a[i])
        for (int j = 0; j <= w; j++) a[i+j] = a[i+j] ^ pf[j];
    r = '0;
    for (int j = 0; j < w; j++) r[w-1-j] = a[n+j];
    return r;
  endfunction

  // driver tasks: all called and returning at a negative clock edge
  task automatic start_op(input logic m, input int n);
    start = 1'b1;
    mode  = m;
    len   = 11'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bits(input logic [127:0] msg, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int b = 0;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      while (!o_din_ready && b < 50) begin
        @(negedge clk);
        b++;
      end
      if (b >= 50) begin
        check("din_ready_timeout", 0, 1);
        return;
      end
      din_valid = 1'b1;
      din       = msg[i];
      @(negedge clk);
      din_valid = 1'b0;
      din       = 1'b0;
    end
  endtask

  task automatic collect(input int n, input int stall_at, input int poke_at,
                         input bit rnd_ready, output logic [15:0] word);
    int got = 0;
    int budget = 0;
    int stalls = 0;
    bit holding = 0;
    bit poked = 0;
    logic held = 1'b0;
    word = '0;
    while (got < n && budget < 500) begin
      start = 1'b0;
      if (o_valid) begin
        if (holding) check("crc_out_hold", o_bit, held);
        if (got == stall_at && stalls < 3) begin
          out_ready = 1'b0;
          stalls++;
        end else begin
          out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        if (got == poke_at && !poked) begin
          start = 1'b1;
          mode  = 1'b1;
          len   = 11'd0;
          poked = 1;
        end
        if (out_ready) begin
          word = {word[14:0], o_bit};
          got++;
          holding = 0;
        end else begin
          holding = 1;
          held    = o_bit;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
      budget++;
    end
    out_ready = 1'b0;
    start     = 1'b0;
    if (budget >= 500) check("emit_timeout", 0, 1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("done_clear", o_done, 0);
    check("crc_ok_clear", o_ok, 0);
    check("busy_idle", o_busy, 0);
  endtask

  task automatic wait_done();
    int b = 0;
    while (!o_done && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (b >= 100) check("done_timeout", 0, 1);
  endtask

  task automatic run_gen(input logic [127:0] msg, input int n, input bit gaps,
                         input int stall_at, input int poke_at, input bit rnd_ready,
                         output logic [15:0] emitted);
    logic [15:0] mask, exp_crc;
    logic [15:0] exp_q[$];
    int w = cur_w();
    mask    = (16'h1 << w) - 16'h1;
    if (w == 16) mask = 16'hFFFF;
    exp_crc = ~model_rem(msg, n, w, cur_poly()) & mask;
    exp_q.push_back(exp_crc);
    start_op(1'b0, n);
    if (n > 0) send_bits(msg, n, gaps);
    check("emit_latency", o_valid, 1);
    collect(w, stall_at, poke_at, rnd_ready, emitted);
    wait_done();
    check("crc_out_seq", emitted, exp_q.pop_front());
    check("gen_done", o_done, 1);
    check("crc_value", o_value, exp_crc);
    check("gen_crc_ok_low", o_ok, 0);
    do_ack();
  endtask

  task automatic run_check(input logic [127:0] msg, input int n, input bit exp_ok);
    start_op(1'b1, n);
    send_bits(msg, n, 1);
    check("check_latency", o_done, 1);
    check("crc_ok", o_ok, exp_ok);
    do_ack();
  endtask

  task automatic round_trip(input int n);
    logic [127:0] m, m2;
    logic [15:0] emitted;
    int w = cur_w();
    int flip;
    m = '0;
    m[31:0]  = $urandom;
    m[63:32] = $urandom;
    if (n < 64) m[127:0] = m & ((128'h1 << n) - 128'h1);
    run_gen(m, n, 1, $urandom_range(0, w - 1), -1, 1, emitted);
    for (int j = 0; j < w; j++) m[n+j] = emitted[w-1-j];
    check("model_residual", model_rem(m, n + w, w, cur_poly()), cur_res());
    run_check(m, n + w, model_rem(m, n + w, w, cur_poly()) == cur_res());
    m2 = m;
    flip = $urandom_range(0, n + w - 1);
    m2[flip] = ~m2[flip];
    run_check(m2, n + w, model_rem(m2, n + w, w, cur_poly()) == cur_res());
  endtask

  initial begin
    logic [127:0] m;
    logic [15:0] emitted;
    rst_n = 1'b0;
    {start, mode, abort, din_valid, din, out_ready, ack, sel5} = '0;
    len = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_valid", o_valid, 0);
    check("rst_din_ready", o_din_ready, 0);
    check("rst_crc_value", o_value, 0);
    check("rst_state", o_state, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed CRC16 vectors
    m = '0;
    m[0] = 1'b1;
    run_gen(m, 1, 0, -1, -1, 0, emitted);
    check("tp_len1_d1", emitted, 16'h0001);
    m[0] = 1'b0;
    run_gen(m, 1, 0, 5, -1, 0, emitted);
    check("tp_len1_d0_stall", emitted, 16'h8004);
    run_gen(m, 0, 0, -1, 4, 0, emitted);
    check("tp_len0_start_ignored", emitted, 16'h0000);

    // abort together with start mid-DATA
    m[31:0] = $urandom;
    start_op(1'b0, 20);
    send_bits(m, 5, 0);
    abort = 1'b1;
    start = 1'b1;
    len   = 11'd7;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    repeat (3) @(negedge clk);
    check("abort_still_idle", o_busy, 0);
    check("abort_no_done", o_done, 0);

    for (int it = 0; it < 3; it++) round_trip(64);
    sel5 = 1'b1;
    @(negedge clk);
    for (int it = 0; it < 3; it++) round_trip(11);
    sel5 = 1'b0;
    @(negedge clk);

    // asynchronous reset mid-EMIT
    m[0] = 1'b0;
    start_op(1'b0, 1);
    send_bits(m, 1, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("pre_rst_value", o_value, 16'h8004);
    rst_n = 1'b0;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_bit", o_bit, 0);
    check("arst_value", o_value, 0);
    check("arst_busy", o_busy, 0);
    check("arst_done", o_done, 0);
    check("arst_state", o_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_gen(m, 1, 0, -1, -1, 0, emitted);
    check("post_rst_gen", emitted, 16'h8004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/usb_crc_engine.md
Name: usb_crc_engine

Overview:
- Parametrised serial CRC engine for the USB packet path. A single RTL block covers CRC5 for tokens and CRC16 for data by changing parameters.
- Generate mode: absorbs a runtime-programmed number of bits LSB-first, then emits the complemented remainder MSB-first under backpressure.
- Check mode: absorbs data plus the received CRC and flags a match against the polynomial residual.
- Sits between the bit-stuffer/NRZI layers and the packet encoder/decoder FSMs.

Parameters:
- CRC_W, 16, remainder width (5 for CRC5, 16 for CRC16).
- POLY, 16'h8005, generator taps without the x^CRC_W term; CRC5 uses 5'h05.
- RESIDUAL, 16'h800D, check-mode good residual; CRC5 uses 5'h0C.
- LEN_W, 11, width of the bit-length field; covers up to 2047 bits.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle request; latches len and mode; honoured only in IDLE
- mode  input  1  0 = generate, 1 = check
- len  input  LEN_W  number of bits to absorb (check mode counts the CRC bits too)
- abort  input  1  synchronous return to IDLE from any state
- din_valid  input  1  din is valid this cycle
- din  input  1  serial data bit
- din_ready  output  1  engine accepts a bit this cycle
- crc_out_valid  output  1  crc_out carries a remainder bit
- crc_out  output  1  serial complemented remainder, MSB first
- out_ready  input  1  downstream consumes crc_out this cycle
- crc_value  output  CRC_W  parallel complemented remainder; valid in DONE, generate mode
- done  output  1  operation complete; held until ack
- crc_ok  output  1  check result; valid while done
- ack  input  1  acknowledges done
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset values:
  - FSM = IDLE; CRC register = all ones; count = 0; shift register = 0.
  - All outputs 0, except crc_value = 0.
- Register update, on each accepted bit (din_valid & din_ready):
  - fb = crc[CRC_W-1] ^ din
  - crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY[CRC_W-1:0] : 0)
  - count increments by 1.
- IDLE:
  - start loads crc = all ones, count = 0, and latches len/mode.
  - len != 0 → DATA.
  - len == 0 and generate → EMIT.
  - len == 0 and check → DONE with crc_ok = (all ones == RESIDUAL).
- DATA:
  - din_ready = 1; din_valid may stall indefinitely with no state change.
  - On the accepted bit where count == len-1:
    - generate → EMIT; shift register loads ~crc_next.
    - check → DONE; crc_ok registers (crc_next == RESIDUAL).
- EMIT:
  - crc_out_valid = 1; crc_out = shift register MSB.
  - The register shifts left only when out_ready = 1.
  - After CRC_W accepted bits → DONE.
  - crc_value = ~final crc, stable from EMIT entry.
- DONE:
  - done = 1; crc_ok held (always 0 in generate mode).
  - ack → IDLE; done and crc_ok clear on the same edge.
- start is ignored outside IDLE.
- abort has priority over start, ack and data. It returns to IDLE next edge with crc_ok cleared; the CRC register is not reinitialised until the next start.
- Latency:
  - generate: first crc_out bit is valid the cycle after the last data bit is accepted;
  - check: done asserts the cycle after the last bit is accepted.
- Asynchronous reset mid-operation returns all state to reset values immediately.
- count saturates at no value: len ≤ 2^LEN_W-1 by construction; count never exceeds len-1.

Test Plan:
- CRC16 generate, len=1, din=1 → register 0xFFFE; emits 15 zeros then 1; crc_value = 0x0001.
- CRC16 generate, len=1, din=0 → register 0x7FFB; emits 1000_0000_0000_0100; crc_value = 0x8004.
- CRC16 generate, len=0 → straight to EMIT; emits 16 zeros; done; ack returns to IDLE.
- Round trip with a random 64-bit payload: generate CRC16, then check mode with len=80 over payload plus emitted CRC → crc_ok=1. Flip any single bit → crc_ok=0. Repeat with CRC_W=5, POLY=5'h05, RESIDUAL=5'h0C, 11-bit token payload.
- Stalls: random din_valid gaps and out_ready low for 3 cycles mid-EMIT → identical crc_out sequence; crc_out is held while out_ready=0.
- Interference cases:
  - abort asserted mid-DATA, together with start → back to IDLE; busy=0 next cycle; no done.
  - start during EMIT → ignored.
  - rst_n pulsed mid-EMIT → all outputs 0 immediately.
